// File: rtl/lcd_text_driver.sv
// lcd_text_driver: HD44780 4-bit text frame writer; define LCD_AUTO_REFRESH_EN for continuous refresh
module lcd_text_driver #(
  parameter int CLK_DIV     = 1000000,
  parameter int NUM_LINES   = 2,
  parameter int LINE_CHARS  = 16,
  parameter int CLEAR_TICKS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_LINES*LINE_CHARS*8-1:0] text,
  output logic                              busy,
  output logic                              done,
  output logic                              lcd_e,
  output logic                              lcd_rs,
  output logic                              lcd_rw,
  output logic [3:0]                        lcd_data
);
  localparam int TW = NUM_LINES * LINE_CHARS * 8;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [3:0] INIT_NIB [16] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC,
                                           4'h0, 4'h6, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
  typedef enum logic [2:0] {INIT, CLR_WAIT, IDLE, ADDR, CHAR, FIN} state_t;
  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [1:0]      ph, ph_n;
  logic            lo, lo_n;
  logic [15:0]     ni, ni_n;
  logic [5:0]      ch, ch_n;
  logic            line, line_n;
  logic [TW-1:0]   frame;
  logic            tick, nend, load, clr_cnt, shift, rs_c;
  logic [3:0]      nib;
  logic [7:0]      chr;
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign nend = tick && ph == 2'd2;
  assign chr  = frame[TW-1 -: 8];
  // phase tick divider; restarts on frame acceptance so the first nibble gets a full phase
  always_ff @(posedge clk)
    if (rst || clr_cnt) cnt <= '0;
    else cnt <= tick ? '0 : cnt + CW'(1);
  // frame buffer: latched on acceptance, shifted one character left after each character byte
  always_ff @(posedge clk)
    if (rst) frame <= '0;
    else if (load) frame <= text;
    else if (shift) frame <= frame << 8;
  // sequencer state register
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      ph    <= 2'd0;
      lo    <= 1'b0;
      ni    <= '0;
      ch    <= '0;
      line  <= 1'b0;
    end else begin
      state <= state_n;
      ph    <= ph_n;
      lo    <= lo_n;
      ni    <= ni_n;
      ch    <= ch_n;
      line  <= line_n;
    end
  // next-state and bus value; a nibble spans phases 0..2 and the byte's high nibble goes first
  always_comb begin
    state_n = state;
    ph_n    = tick ? (ph == 2'd2 ? 2'd0 : ph + 2'd1) : ph;
    lo_n    = lo;
    ni_n    = ni;
    ch_n    = ch;
    line_n  = line;
    nib     = 4'h0;
    rs_c    = 1'b0;
    load    = 1'b0;
    clr_cnt = 1'b0;
    shift   = 1'b0;
    case (state)
      INIT: begin
        nib = INIT_NIB[ni[3:0]];
        if (nend) begin
          ni_n = ni + 16'd1;
          if (ni == 16'd11) begin
            ni_n    = '0;
            state_n = (CLEAR_TICKS == 0) ? IDLE : CLR_WAIT;
          end
        end
      end
      CLR_WAIT: begin
        ph_n = 2'd0;
        if (tick) begin
          ni_n = ni + 16'd1;
          if (ni == 16'(CLEAR_TICKS - 1)) begin
            ni_n    = '0;
            state_n = IDLE;
          end
        end
      end
      IDLE: begin
        ph_n = 2'd0;
        if (start) begin
          load    = 1'b1;
          clr_cnt = 1'b1;
          lo_n    = 1'b0;
          ch_n    = '0;
          line_n  = 1'b0;
          state_n = ADDR;
        end
      end
      ADDR: begin
        nib = lo ? 4'h0 : {1'b1, line, 2'b00};
        if (nend) begin
          lo_n = !lo;
          if (lo) begin
            ch_n    = '0;
            state_n = CHAR;
          end
        end
      end
      CHAR: begin
        rs_c = 1'b1;
        nib  = lo ? chr[3:0] : chr[7:4];
        if (nend) begin
          lo_n = !lo;
          if (lo) begin
            shift = 1'b1;
            ch_n  = ch + 6'd1;
            if (ch == 6'(LINE_CHARS - 1)) begin
              ch_n = '0;
              if (line == 1'(NUM_LINES - 1)) state_n = FIN;
              else begin
                line_n  = 1'b1;
                state_n = ADDR;
              end
            end
          end
        end
      end
      FIN: begin
`ifdef LCD_AUTO_REFRESH_EN
        // the FIN cycle already presents the line-0 address nibble so its setup time is a full phase
        nib     = 4'h8;
        load    = 1'b1;
        lo_n    = 1'b0;
        ch_n    = '0;
        line_n  = 1'b0;
        state_n = ADDR;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = INIT;
    endcase
  end
  assign busy     = rst || !(state == IDLE || state == FIN);
  assign done     = !rst && state == FIN;
  assign lcd_e    = !rst && ph == 2'd1 && (state == INIT || state == ADDR || state == CHAR);
  assign lcd_rs   = !rst && rs_c;
  assign lcd_rw   = 1'b0;
  assign lcd_data = rst ? 4'h0 : nib;
endmodule

// File: tb/tb_lcd_text_driver.sv
// tb_lcd_text_driver: directed checks of init, frame write, E timing, start-while-busy and mid-frame reset
module tb_lcd_text_driver;
  localparam int TW = 2 * 16 * 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [TW-1:0] text = '0;
  logic busy, done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_data;
  int tests = 0, fails = 0;
  typedef struct {string name; logic [4:0] exp;} vec_t;
  vec_t init_tab [12];
  logic [4:0] cap [$];
  logic [4:0] expq [$];
  logic [4:0] keep [$];
  logic pe;
  logic [4:0] pd;
  int hi, stab, sf;

  lcd_text_driver #(.CLK_DIV(4), .NUM_LINES(2), .LINE_CHARS(16), .CLEAR_TICKS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .text(text), .busy(busy), .done(done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // bus monitor: captures {rs,data} at each E rise and checks E width and setup/hold windows
  always @(negedge clk) begin
    if (rst) begin
      pe = 1'b0; hi = 0; stab = 0; sf = 99;
      pd = {lcd_rs, lcd_data};
    end else begin
      if (sf < 99) sf++;
      if ({lcd_rs, lcd_data} !== pd) begin
        chk("bus hold", {31'd0, !lcd_e && sf >= 4}, 1);
        stab = 0;
      end else stab++;
      if (lcd_e && !pe) begin
        cap.push_back({lcd_rs, lcd_data});
        chk("bus setup", {31'd0, stab >= 4}, 1);
        hi = 0;
      end
      if (lcd_e) hi++;
      if (!lcd_e && pe) begin
        chk("E width", hi, 4);
        sf = 0;
      end
      chk("rw low", lcd_rw, 0);
      pe = lcd_e;
      pd = {lcd_rs, lcd_data};
    end
  end

  function automatic void build(input logic [TW-1:0] t);
    logic [7:0] b;
    expq.delete();
    for (int l = 0; l < 2; l++) begin
      expq.push_back(l == 0 ? 5'h08 : 5'h0C);
      expq.push_back(5'h00);
      for (int c = 0; c < 16; c++) begin
        b = t[TW-1-8*(l*16+c) -: 8];
        expq.push_back({1'b1, b[7:4]});
        expq.push_back({1'b1, b[3:0]});
      end
    end
  endfunction

  task automatic cmp_frame(input string nm, input logic [TW-1:0] t);
    build(t);
    chk({nm, " nibble count"}, keep.size(), 68);
    for (int i = 0; i < keep.size() && i < 68; i++)
      chk($sformatf("%s nib %0d", nm, i), keep[i], expq[i]);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " e"}, lcd_e, 0);
    chk({nm, " rs"}, lcd_rs, 0);
    chk({nm, " rw"}, lcd_rw, 0);
    chk({nm, " data"}, lcd_data, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " busy"}, busy, 1);
  endtask

  task automatic release_and_init(input string nm);
    int n;
    @(posedge clk); #1 rst = 1'b0;
    cap.delete();
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (n == 0) chk({nm, " no E after reset"}, lcd_e, 0);
      if (!busy) break;
      n++;
    end
    chk({nm, " busy fall cycle"}, n, 152);
    chk({nm, " init nibble count"}, cap.size(), 12);
    for (int i = 0; i < 12 && i < cap.size(); i++)
      chk({nm, " ", init_tab[i].name}, cap[i], init_tab[i].exp);
  endtask

  task automatic accept(input logic [TW-1:0] t);
    text = t;
    cap.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] ta, tb2;
    logic [47:0] seq;
    int k, dk, dn;
    seq = 48'h3332_280C_0601;
    for (int i = 0; i < 12; i++) begin
      init_tab[i].name = $sformatf("init nib %0d", i);
      init_tab[i].exp  = {1'b0, seq[47-4*i -: 4]};
    end
    ta  = "HELLO WORLD 1234CS220 LCD LAB 04";
    tb2 = "0123456789ABCDEFabcdefghijklmnop";

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    release_and_init("init");

`ifdef LCD_AUTO_REFRESH_EN
    accept(ta);
    dk = -1;
    for (k = 0; k < 900; k++) begin
      @(negedge clk);
      if (k == 100) text = tb2;
      if (done) begin dk = k; break; end
    end
    chk("auto first done cycle", dk, 816);
    chk("auto busy in FIN", busy, 0);
    keep = cap;
    cap.delete();
    cmp_frame("auto frame 1", ta);
    @(negedge clk);
    chk("auto busy after FIN", busy, 1);
    dk = -1;
    for (k = 2; k < 900; k++) begin
      @(negedge clk);
      if (done) begin dk = k; break; end
    end
    chk("auto done period", dk, 816);
    keep = cap;
    cmp_frame("auto frame 2", tb2);
`else
    accept(ta);
    text = tb2;
    dk = -1; dn = 0;
    for (k = 0; k < 830; k++) begin
      @(negedge clk);
      start = (k == 100);
      if (done) begin
        dn++;
        if (dk < 0) dk = k;
        chk("busy low in done cycle", busy, 0);
      end
      if (k == 817) chk("idle after frame", busy, 0);
    end
    chk("done cycle after accept", dk, 816);
    chk("done pulse count", dn, 1);
    keep = cap;
    cmp_frame("frame A", ta);

    accept(tb2);
    for (k = 0; k < 300; k++) @(negedge clk);
    chk("busy mid-frame", busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("mid-frame reset");
    release_and_init("re-init");

    accept(tb2);
    dk = -1;
    for (k = 0; k < 830; k++) begin
      @(negedge clk);
      if (done && dk < 0) dk = k;
    end
    chk("frame B done cycle", dk, 816);
    keep = cap;
    cmp_frame("frame B", tb2);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_text_driver.md
LCD_TEXT_DRIVER -- requirements
Module: lcd_text_driver

Interface
REQ-001 Parameter CLK_DIV, default 1000000, clk cycles per phase tick (minimum 2).
REQ-002 Parameter NUM_LINES, default 2, number of display lines written per frame (1 or 2).
REQ-003 Parameter LINE_CHARS, default 16, characters per line (1..40).
REQ-004 Parameter CLEAR_TICKS, default 2, extra idle ticks after the clear-display command.
REQ-005 clk  input  1  sole clock; all logic on posedge clk.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  frame request; sampled only when busy is low.
REQ-008 text  input  NUM_LINES*LINE_CHARS*8  ASCII frame; line 0 char 0 at MSB byte; latched on start acceptance.
REQ-009 busy  output  1  high during init and frame write.
REQ-010 done  output  1  one-cycle pulse at frame completion.
REQ-011 lcd_e, lcd_rs, lcd_rw  output  1 each  HD44780 enable, register select, read/write (rw always 0).
REQ-012 lcd_data  output  4  nibble bus.

Function
REQ-013 Tick: counter 0..CLK_DIV-1; tick asserted in the cycle the counter equals CLK_DIV-1, then the counter wraps to 0; all sequencing advances only on tick.
REQ-014 Nibble transfer = 3 ticks: P0 drive rs/data with e=0; P1 e=1; P2 e=0; rs/data held stable through P2.
REQ-015 Byte = high nibble then low nibble (6 ticks).
REQ-016 States: INIT, CLR_WAIT, IDLE, ADDR, CHAR, FIN.
REQ-017 INIT: rs=0 nibbles 3,3,3,2, then bytes 0x28, 0x0C, 0x06, 0x01 (12 nibbles); then CLR_WAIT for CLEAR_TICKS ticks; then IDLE.
REQ-018 IDLE: busy=0; start=1 latches text, sets busy=1 next cycle, resets line/char indices to 0 and the tick counter to 0, goes to ADDR.
REQ-019 ADDR: rs=0 byte 0x80 for line 0, 0xC0 for line 1; then CHAR.
REQ-020 CHAR: rs=1 byte per character, left to right; after char LINE_CHARS-1, go to ADDR for the next line, or to FIN after line NUM_LINES-1.
REQ-021 FIN: done=1 for exactly one clk cycle, busy=0 in the same cycle, then IDLE.
REQ-022 start while busy=1 is ignored; no queueing.
REQ-023 Changes on text after acceptance do not affect the frame in progress.
REQ-024 Frame length = NUM_LINES*(LINE_CHARS+1)*6 ticks.

Reset
REQ-025 rst=1: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0, done=0, busy=1, counter=0, state=INIT at the first nibble.
REQ-026 rst asserted mid-frame or mid-init aborts immediately, with no partial E pulse beyond the reset cycle, and restarts the full init sequence.

Configuration
REQ-027 Macro LCD_AUTO_REFRESH_EN defined: FIN pulses done, then relatches text and re-enters ADDR at line 0 without start; busy stays 1 except in the FIN cycle.
REQ-028 Macro LCD_AUTO_REFRESH_EN undefined: the behaviour in REQ-021 applies; a new frame requires start.

Verification (CLK_DIV=4, NUM_LINES=2, LINE_CHARS=16, CLEAR_TICKS=2)
REQ-029 Release rst -> nibbles 3,3,3,2,2,8,0,C,0,6,0,1 with rs=0; busy falls 152 cycles after release.
REQ-030 start with text "HELLO WORLD 1234" / "CS220 LCD LAB 04" -> nibbles 8,0,4,8,... then C,0,4,3,...; done pulse 816 cycles after acceptance.
REQ-031 E timing check -> every E high lasts exactly 4 cycles; rs/data are unchanged from 4 cycles before E rises until 4 cycles after E falls.
REQ-032 start pulsed at cycle 100 of a frame -> ignored; exactly one done pulse.
REQ-033 rst at cycle 300 of a frame -> outputs at reset values the next cycle, then the full REQ-029 sequence repeats.
REQ-034 LCD_AUTO_REFRESH_EN defined, text changed mid-frame -> the current frame is unchanged; the next frame shows the new text; done pulses every 816 cycles.
